// File: rtl/alu_req_queue.sv
// ---------------------------------------------------------------------------
// alu_req_queue
//   Request FIFO sitting in front of the ALU_LI block. Upstream {a, b, op}
//   requests are buffered in a DEPTH-entry circular queue. The head entry is
//   presented to the ALU with a valid/ready handshake.
//
//   Every output is driven from registered state only. There is no
//   combinational path from req_* to alu_*, and none from alu_ready to
//   req_ready.
//
// Parameters
//   WIDTH      operand width in bits (default 32)
//   DEPTH      queue entries; a power of two, at least 2 (default 4)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   req_a      upstream operand A
//   req_b      upstream operand B
//   req_op     upstream opcode (0 = add, 1 = mul), stored unchanged
//   req_valid  upstream request valid
//   req_ready  queue has a free entry (count < DEPTH)
//   alu_a      head operand A, zero when the queue is empty
//   alu_b      head operand B, zero when the queue is empty
//   alu_op     head opcode, zero when the queue is empty
//   alu_valid  queue is not empty
//   alu_ready  ALU accepts the head entry
//   count      number of occupied entries
//
// Optional feature (macro ALU_REQ_QUEUE_STATS_EN)
//   Adds push_total / pop_total: free-running 32-bit counters of accepted
//   pushes and pops. They reset to 0 and wrap at 2^32.
// ---------------------------------------------------------------------------
module alu_req_queue #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         req_a,
  input  logic [WIDTH-1:0]         req_b,
  input  logic                     req_op,
  input  logic                     req_valid,
  output logic                     req_ready,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic                     alu_op,
  output logic                     alu_valid,
  input  logic                     alu_ready,
  output logic [$clog2(DEPTH):0]   count
`ifdef ALU_REQ_QUEUE_STATS_EN
  ,
  output logic [31:0]              push_total,
  output logic [31:0]              pop_total
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = 2 * WIDTH + 1;

  // Reject illegal DEPTH values at elaboration.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("alu_req_queue: DEPTH must be a power of two and at least 2");
  end

  // Packed entry layout: {a, b, op}.
  typedef logic [EW-1:0] entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic            not_full;
  logic            not_empty;
  logic            push;
  logic            pop;
  entry_t          head;

  // ------------------------------------------------------------------------
  // Status flags, derived from the registered count only. Full and empty are
  // taken from count because the pointers are equal in both states.
  // ------------------------------------------------------------------------
  assign not_full  = (count_q < CW'(DEPTH));
  assign not_empty = (count_q != '0);

  // A pop in the same cycle does not free a slot for a push when full:
  // req_ready looks at registered state only.
  assign push = req_valid & not_full;
  assign pop  = not_empty & alu_ready;

  // ------------------------------------------------------------------------
  // Pointer and occupancy next-state logic. DEPTH is a power of two, so the
  // natural PW-bit rollover gives modulo-DEPTH wrapping.
  // ------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;  // idle, or push and pop cancel out
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ------------------------------------------------------------------------
  // Storage array. It has no reset; the head mux below masks stale contents
  // whenever the queue is empty.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {req_a, req_b, req_op};
    end
  end

  assign head = mem[rd_ptr_q];

  // ------------------------------------------------------------------------
  // Outputs. The head is forced to zero when empty, so reset clears the ALU
  // outputs asynchronously through count_q.
  // ------------------------------------------------------------------------
  always_comb begin
    alu_a = '0;
    alu_b = '0;
    alu_op = 1'b0;
    if (not_empty) begin
      alu_a  = head[EW-1 -: WIDTH];
      alu_b  = head[WIDTH -: WIDTH];
      alu_op = head[0];
    end
  end

  assign alu_valid = not_empty;
  assign req_ready = not_full;
  assign count     = count_q;

`ifdef ALU_REQ_QUEUE_STATS_EN
  // ------------------------------------------------------------------------
  // Transfer statistics. The counters wrap naturally at 32 bits.
  // ------------------------------------------------------------------------
  logic [31:0] push_total_q;
  logic [31:0] pop_total_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push_total_q <= '0;
      pop_total_q  <= '0;
    end else begin
      if (push) begin
        push_total_q <= push_total_q + 32'd1;
      end
      if (pop) begin
        pop_total_q <= pop_total_q + 32'd1;
      end
    end
  end

  assign push_total = push_total_q;
  assign pop_total  = pop_total_q;
`endif

endmodule

// File: tb/tb_alu_req_queue.sv
// ---------------------------------------------------------------------------
// tb_alu_req_queue
//   Self-checking bench for alu_req_queue (WIDTH = 32, DEPTH = 4).
//   - Reset state, including asynchronous behaviour before any clock edge.
//   - Table of directed vectors: fill, overflow, pop-only when full, drain.
//   - Hand sequences: same-cycle push/pop at count 2, mid-cycle reset.
//   - Randomised traffic checked against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_alu_req_queue;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             req_op;
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_op;
  logic             alu_valid;
  logic             alu_ready;
  logic [2:0]       count;
`ifdef ALU_REQ_QUEUE_STATS_EN
  logic [31:0]      push_total;
  logic [31:0]      pop_total;
`endif

  alu_req_queue #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .count     (count)
`ifdef ALU_REQ_QUEUE_STATS_EN
    ,
    .push_total (push_total),
    .pop_total  (pop_total)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an ordered list of the entries held in the queue.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op;
  } entry_t;

  entry_t q[$];
  int unsigned n_push;
  int unsigned n_pop;

  int n_cmp;
  int n_fail;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Advances one clock edge. The model decides push/pop from the request
  // rules and updates its list of entries to match.
  task automatic step();
    bit do_push;
    bit do_pop;
    entry_t e;
    do_push = (req_valid === 1'b1) && (q.size() < DEPTH);
    do_pop  = (q.size() != 0) && (alu_ready === 1'b1);
    e = '{a: req_a, b: req_b, op: req_op};
    @(posedge clk);
    if (do_pop) begin
      void'(q.pop_front());
      n_pop++;
    end
    if (do_push) begin
      q.push_back(e);
      n_push++;
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    entry_t h;
    h = '0;
    if (q.size() != 0) h = q[0];
    check({tag, ".count"},     64'(count),     64'(q.size()));
    check({tag, ".req_ready"}, 64'(req_ready), 64'(q.size() < DEPTH));
    check({tag, ".alu_valid"}, 64'(alu_valid), 64'(q.size() != 0));
    check({tag, ".alu_a"},     64'(alu_a),     64'(h.a));
    check({tag, ".alu_b"},     64'(alu_b),     64'(h.b));
    check({tag, ".alu_op"},    64'(alu_op),    64'(h.op));
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic op, input logic rdy);
    req_valid = v;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    alu_ready = rdy;
  endtask

  // Directed vectors: inputs applied before an edge, expected outputs after.
  typedef struct {
    logic             v;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op;
    logic             rdy;
    int unsigned      e_count;
    logic             e_ready;
    logic             e_valid;
    logic [WIDTH-1:0] e_a;
    logic [WIDTH-1:0] e_b;
    logic             e_op;
  } vec_t;

  vec_t vecs[11];

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    n_push = 0;
    n_pop  = 0;

    //          v  a             b             op rdy  cnt rdy val  a             b             op
    vecs[0]  = '{1, 32'h3F800000, 32'h40000000, 0, 0,   1,  1,  1,  32'h3F800000, 32'h40000000, 0};
    vecs[1]  = '{1, 32'h00000011, 32'h00000022, 1, 0,   2,  1,  1,  32'h3F800000, 32'h40000000, 0};
    vecs[2]  = '{1, 32'h00000033, 32'h00000034, 1, 0,   3,  1,  1,  32'h3F800000, 32'h40000000, 0};
    vecs[3]  = '{1, 32'h00000044, 32'h00000045, 0, 0,   4,  0,  1,  32'h3F800000, 32'h40000000, 0};
    vecs[4]  = '{1, 32'h00000055, 32'h00000056, 1, 0,   4,  0,  1,  32'h3F800000, 32'h40000000, 0};
    vecs[5]  = '{1, 32'h00000066, 32'h00000067, 1, 1,   3,  1,  1,  32'h00000011, 32'h00000022, 1};
    vecs[6]  = '{0, 32'h00000000, 32'h00000000, 0, 1,   2,  1,  1,  32'h00000033, 32'h00000034, 1};
    vecs[7]  = '{1, 32'h00000077, 32'h00000078, 1, 1,   2,  1,  1,  32'h00000044, 32'h00000045, 0};
    vecs[8]  = '{0, 32'h00000000, 32'h00000000, 0, 1,   1,  1,  1,  32'h00000077, 32'h00000078, 1};
    vecs[9]  = '{0, 32'h00000000, 32'h00000000, 0, 1,   0,  1,  0,  32'h00000000, 32'h00000000, 0};
    vecs[10] = '{0, 32'hDEADBEEF, 32'hCAFEF00D, 1, 1,   0,  1,  0,  32'h00000000, 32'h00000000, 0};

    // Reset is asserted before the first clock edge and must already hold.
    reset = 1'b1;
    drive(0, '0, '0, 0, 0);
    #1;
    check("reset.count",     64'(count),     64'd0);
    check("reset.alu_valid", 64'(alu_valid), 64'd0);
    check("reset.req_ready", 64'(req_ready), 64'd1);
    check("reset.alu_a",     64'(alu_a),     64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed table; the first push lands on the first edge after reset.
    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].rdy);
      step();
      check($sformatf("vec%0d.count", i),     64'(count),     64'(vecs[i].e_count));
      check($sformatf("vec%0d.req_ready", i), 64'(req_ready), 64'(vecs[i].e_ready));
      check($sformatf("vec%0d.alu_valid", i), 64'(alu_valid), 64'(vecs[i].e_valid));
      check($sformatf("vec%0d.alu_a", i),     64'(alu_a),     64'(vecs[i].e_a));
      check($sformatf("vec%0d.alu_b", i),     64'(alu_b),     64'(vecs[i].e_b));
      check($sformatf("vec%0d.alu_op", i),    64'(alu_op),    64'(vecs[i].e_op));
    end

    // Push into an empty queue with alu_ready high: visible next cycle,
    // popped on the following edge.
    drive(1, 32'h3F800000, 32'h40000000, 0, 1);
    step();
    check("lat.alu_valid", 64'(alu_valid), 64'd1);
    check("lat.alu_a",     64'(alu_a),     64'h3F800000);
    drive(0, '0, '0, 0, 1);
    step();
    check("lat.count", 64'(count), 64'd0);

    // Reach count 2, then push and pop together for 10 cycles.
    drive(1, 32'hA0000001, 32'hB0000001, 1, 0);
    step();
    drive(1, 32'hA0000002, 32'hB0000002, 0, 0);
    step();
    for (int i = 0; i < 10; i++) begin
      drive(1, $urandom, $urandom, 1'($urandom), 1);
      step();
      check_model($sformatf("pp%0d", i));
      check($sformatf("pp%0d.count2", i), 64'(count), 64'd2);
    end

    // Build count 3, then assert reset between edges.
    drive(1, 32'h11111111, 32'h22222222, 1, 0);
    step();
    check("prerst.count", 64'(count), 64'd3);
    drive(0, '0, '0, 0, 1);
    #2;
    reset = 1'b1;
    q.delete();
    #1;
    check("midrst.count",     64'(count),     64'd0);
    check("midrst.alu_valid", 64'(alu_valid), 64'd0);
    check("midrst.req_ready", 64'(req_ready), 64'd1);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_model($sformatf("postrst%0d", i));
    end
    drive(1, 32'h0BADF00D, 32'h00C0FFEE, 1, 0);
    step();
    check_model("postrst.push");

    // Randomised traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom),
            1'($urandom_range(0, 3) != 0));
      step();
      check_model($sformatf("rnd%0d", i));
    end

    // Drain what is left in the queue.
    drive(0, '0, '0, 0, 1);
    for (int i = 0; i < DEPTH + 1; i++) begin
      step();
    end
    check_model("drain");

`ifdef ALU_REQ_QUEUE_STATS_EN
    check("stats.push_total", 64'(push_total), 64'(n_push));
    check("stats.pop_total",  64'(pop_total),  64'(n_pop));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
